// File: rtl/bch2_serial_decoder.sv
// rtl/bch2_serial_decoder.sv - bit-serial t=2 binary BCH decoder over GF(2^M)
// Optional macro BCH_DEC_ERR_CNT_EN adds o_out_nerr (corrections applied, valid with o_out_last).
module bch2_serial_decoder #(
  parameter int M    = 6,
  parameter int POLY = 'h43
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_in_data,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  output logic       o_out_data,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic       o_out_last,
  output logic       o_out_fail
`ifdef BCH_DEC_ERR_CNT_EN
  ,
  output logic [1:0] o_out_nerr
`endif
);

  localparam int N = (1 << M) - 1;
  localparam logic [M-1:0] PLOW     = POLY[M-1:0];
  localparam logic [M-1:0] ONE      = M'(1);
  localparam logic [M-1:0] ALPHA    = M'(2);
  localparam logic [M-1:0] CNT_LAST = M'(N - 1);
  localparam logic [M-1:0] INV_LAST = M'(M - 2);

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p;
    p = '0;
    for (int i = M - 1; i >= 0; i--) begin
      p = {p[M-2:0], 1'b0} ^ (p[M-1] ? PLOW : '0);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  localparam logic [M-1:0] ALPHA3 = gf_mul(gf_mul(ALPHA, ALPHA), ALPHA);

  typedef enum logic [1:0] {S_RECV, S_INV, S_SIG, S_OUT} state_t;

  state_t       r_state, w_state_next;
  logic [M-1:0] r_cnt;
  logic [N-1:0] r_buf;
  logic [M-1:0] r_s1, r_s3, r_sq, r_acc, r_sig1, r_sig2, r_e;
  logic [1:0]   r_d, r_roots;
  logic         r_fail_pre;

  logic         w_in_fire, w_out_fire, w_last_beat, w_flip;
  logic [M-1:0] w_s1_next, w_s3_next, w_sq2, w_acc_next, w_sig2, w_e2, w_chien;
  logic [1:0]   w_roots_inc;

  assign w_in_fire   = i_in_valid & (r_state == S_RECV);
  assign w_out_fire  = i_out_ready & (r_state == S_OUT);
  assign w_last_beat = (r_cnt == CNT_LAST);
  assign w_s1_next   = gf_mul(r_s1, ALPHA) ^ {{(M-1){1'b0}}, i_in_data};
  assign w_s3_next   = gf_mul(r_s3, ALPHA3) ^ {{(M-1){1'b0}}, i_in_data};
  // Each INV step squares the running power and folds it in: acc ends at S1^(2+4+..+2^(M-1)).
  assign w_sq2       = gf_mul(r_sq, r_sq);
  assign w_acc_next  = gf_mul(r_acc, w_sq2);
  assign w_sig2      = gf_mul(r_s1, r_s1) ^ gf_mul(r_s3, r_acc);
  assign w_e2        = gf_mul(r_e, r_e);
  assign w_chien     = gf_mul(r_sig1, r_e) ^ gf_mul(r_sig2, w_e2);
  assign w_flip      = (w_chien == ONE);
  assign w_roots_inc = (w_flip && (r_roots != 2'd3)) ? 2'(r_roots + 2'd1) : r_roots;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_RECV;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_in_ready   = 1'b0;
    o_out_valid  = 1'b0;
    o_out_data   = 1'b0;
    o_out_last   = 1'b0;
    o_out_fail   = 1'b0;
`ifdef BCH_DEC_ERR_CNT_EN
    o_out_nerr   = 2'd0;
`endif
    case (r_state)
      S_RECV: begin
        o_in_ready = 1'b1;
        if (w_in_fire && w_last_beat) w_state_next = S_INV;
      end
      S_INV: if (r_cnt == INV_LAST) w_state_next = S_SIG;
      S_SIG: w_state_next = S_OUT;
      S_OUT: begin
        o_out_valid = 1'b1;
        o_out_data  = r_buf[N-1] ^ w_flip;
        o_out_last  = w_last_beat;
        o_out_fail  = w_last_beat & (r_fail_pre | (w_roots_inc != r_d));
`ifdef BCH_DEC_ERR_CNT_EN
        o_out_nerr  = w_last_beat ? w_roots_inc : 2'd0;
`endif
        if (w_out_fire && w_last_beat) w_state_next = S_RECV;
      end
      default: w_state_next = S_RECV;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_buf      <= '0;
      r_s1       <= '0;
      r_s3       <= '0;
      r_sq       <= '0;
      r_acc      <= '0;
      r_sig1     <= '0;
      r_sig2     <= '0;
      r_e        <= '0;
      r_d        <= 2'd0;
      r_roots    <= 2'd0;
      r_fail_pre <= 1'b0;
    end else begin
      case (r_state)
        S_RECV: if (w_in_fire) begin
          r_buf <= {r_buf[N-2:0], i_in_data};
          r_s1  <= w_s1_next;
          r_s3  <= w_s3_next;
          if (w_last_beat) begin
            r_cnt <= '0;
            r_sq  <= w_s1_next;
            r_acc <= ONE;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        S_INV: begin
          r_sq  <= w_sq2;
          r_acc <= w_acc_next;
          r_cnt <= (r_cnt == INV_LAST) ? '0 : r_cnt + ONE;
        end
        S_SIG: begin
          r_sig1     <= r_s1;
          r_sig2     <= w_sig2;
          r_fail_pre <= (r_s1 == '0) && (r_s3 != '0);
          r_d        <= (r_s1 == '0) ? 2'd0 : ((w_sig2 == '0) ? 2'd1 : 2'd2);
          r_e        <= ALPHA;
          r_roots    <= 2'd0;
          r_cnt      <= '0;
        end
        S_OUT: if (w_out_fire) begin
          r_buf   <= {r_buf[N-2:0], 1'b0};
          r_e     <= gf_mul(r_e, ALPHA);
          r_roots <= w_roots_inc;
          if (w_last_beat) begin
            r_cnt <= '0;
            r_s1  <= '0;
            r_s3  <= '0;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bch2_serial_decoder.md
# bch2_serial_decoder

Parametrised, bit-serial, double-error-correcting binary BCH decoder over GF(2^M), with N = 2^M−1 and t = 2 (default M=6 gives BCH(63,51)). It sits in the receive path after the demodulator/slicer, accepts one hard-decision bit per handshake and emits the corrected codeword bit-serially. A fail flag accompanies the last output bit. Decoding is sequential:

- Horner syndromes during reception.
- Square-and-multiply inversion.
- Peterson locator.
- Chien search interleaved with output.

## Interface
- M, 6, field degree; legal range 3..10. N = 2^M−1 is a localparam.
- POLY, 'h43, primitive polynomial (M+1 bits, bit M set); default x^6+x+1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  1  received bit.
- in_valid  in  1  in_data valid.
- in_ready  out  1  decoder accepts in_data.
- out_data  out  1  corrected bit.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts out_data.
- out_last  out  1  marks the final (N-th) output bit.
- out_fail  out  1  uncorrectable indication; meaningful only when out_last=1, otherwise 0.

## Operation

**Ordering**
- Bit order is the same on input and output: coefficient r_{N−1} first, r_0 last.
- Position p of the k-th beat (k = 0..N−1) is p = N−1−k.

**States:** RECV → INV → SIG → OUT → RECV.

**RECV**
- in_ready=1.
- Each accepted bit is written into an N-bit shift buffer.
- Syndrome updates per accepted bit: S1 ← S1·α + r and S3 ← S3·α³ + r (GF multiply mod POLY).
- A beat counter counts to N. The N-th accepted beat moves the block to INV.

**INV** (exactly M−1 cycles, regardless of data)
- Computes S1^(2^M−2) = S1⁻¹ by repeated squaring and multiply.
- S1=0 yields 0.

**SIG** (1 cycle)
- σ1 = S1.
- σ2 = S1² + S3·S1⁻¹.
- Expected root count d:
  - S1=0 and S3=0: d=0.
  - S1≠0 and σ2=0: d=1.
  - S1≠0 and σ2≠0: d=2.
  - S1=0 and S3≠0: d=0 with fail_pre=1.

**OUT** (N beats)
- Chien element e starts at α (= α^−(N−1)) and advances e ← e·α on each accepted output beat.
- Flip condition: σ1·e + σ2·e² = 1 (i.e. σ(e)=0). When it holds, out_data = buffer bit XOR 1 and the root counter increments.
- Root counter is 2 bits and saturates at 3.
- On the last beat, out_fail = fail_pre OR (roots ≠ d).
- Corrections are applied as found, even when out_fail is later raised.

**Arithmetic**
- All field values are M bits.
- Multiply is a shift-and-add product reduced by POLY.
- A single combinational GF multiplier instance per concurrent product is acceptable.

## Timing
- **Reset values:** in_ready=1, out_valid=0, out_data=0, out_last=0, out_fail=0; state RECV; counters, syndromes and buffer cleared.
- **Reset mid-operation:** the partial codeword is discarded and the block restarts in RECV.
- **Input handshake:** a beat transfers on a rising edge with in_valid & in_ready. in_ready drops in the cycle after the N-th transfer.
- **Latency:** out_valid first rises M cycles after the edge that accepted the last input bit (M−1 INV cycles, 1 SIG cycle).
- **Output handshake:** a beat transfers on a rising edge with out_valid & out_ready.
  - out_data, out_last and out_fail hold stable while out_valid=1 and out_ready=0.
  - out_valid has no dependency on out_ready.
- **Return to RECV:** after the out_last transfer, out_valid=0 and in_ready=1 on the next cycle. There is no overlap between codewords; throughput is N input + N output beats + M cycles.
- **in_valid outside RECV** is ignored.

## Configuration
- Macro: BCH_DEC_ERR_CNT_EN.
- **Defined:** adds port out_nerr (out, 2 bits).
  - Carries the number of corrections applied in the codeword, valid with out_last, 0 otherwise.
  - Reset value 0.
- **Undefined:** the port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use M=6 (N=63).
- **All-zero codeword, no errors:** 63 zero bits in → 63 zero bits out; out_fail=0 on beat 62; out_nerr=0; first out_valid exactly 6 cycles after the last input edge.
- **Single error at position 62 (first beat=1, rest 0):** output all zeros; out_fail=0; out_nerr=1. Repeat with the error at position 0 (last beat): same result.
- **Double error at positions 40 and 5 on a valid nonzero codeword (generator polynomial g(x) as codeword):** output equals g(x) bit-exact; out_fail=0; out_nerr=2.
- **Triple error at positions 0, 21, 42 on the zero codeword:** S1=0 and S3=1, so no bits flipped; output equals input; out_fail=1 with out_last.
- **Backpressure:** out_ready toggles 1-0-0-1 throughout the output phase → identical output sequence; out_data stable while stalled; in_ready stays 0 until the cycle after the out_last transfer.
- **Reset mid-operation:** assert rst_n=0 after 30 input beats, then send a clean codeword → all outputs at reset values during reset; the following codeword decodes correctly with out_fail=0.
